// File: rtl/am29_latch_bus_arb_pkg.sv
// Shared definitions for the Am2957-style bus arbiter: FSM state encodings
// and the transfer hold-counter width.
package am29_latch_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } bus_state_t;

    // Wide enough for HOLD_CYCLES up to 255.
    localparam int CNT_W = 8;

endpackage

// File: rtl/am29_rr_pick.sv
// Combinational round-robin picker: the first set request bit strictly after
// 'last', wrapping around, so 'last' itself has the lowest priority.
module am29_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] pos;

    // Scan from the farthest candidate down to the nearest, so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = N; i >= 1; i--) begin
            pos = IDW'((int'(last) + i) % N);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/am29_latch_bus_arb.sv
// Round-robin sequencer for N inverting tristate latches sharing one bus.
// Optional macro BUS_LOCK_EN adds a 'lock' input that chains transfers of one owner.
module am29_latch_bus_arb
    import am29_latch_bus_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int IDW         = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [N-1:0]   req,
`ifdef BUS_LOCK_EN
    input  logic           lock,
`endif
    output logic [N-1:0]   g,
    output logic [N-1:0]   oe_,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [IDW-1:0] owner
);

    bus_state_t     state, state_n;
    logic [IDW-1:0] owner_n, last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic           relock;
    logic [N-1:0]   sel_n;

`ifdef BUS_LOCK_EN
    assign relock = lock;
`else
    assign relock = 1'b0;
`endif

    am29_rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n = state;
        owner_n = owner;
        cnt_n   = cnt;
        last_n  = last;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = LATCH;
                    owner_n = pick_idx;
                end
            end
            LATCH: begin
                state_n = DRIVE;
                cnt_n   = CNT_W'(HOLD_CYCLES - 1);
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (relock) begin
                    // Locked owner re-latches immediately; pointer stays put.
                    state_n = LATCH;
                end else begin
                    state_n = TURN;
                    last_n  = owner;
                end
            end
            TURN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign sel_n = N'(1) << owner_n;

    // Outputs are registered from the next-state values, so they never depend
    // combinationally on req and reset clears the bus drivers asynchronously.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            owner <= '0;
            last  <= IDW'(N - 1);
            cnt   <= '0;
            g     <= '0;
            oe_   <= '1;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            cnt   <= cnt_n;
            g     <= (state_n == LATCH) ? sel_n : '0;
            oe_   <= (state_n == DRIVE) ? ~sel_n : '1;
            grant <= (state_n == LATCH || state_n == DRIVE) ? sel_n : '0;
            done  <= (state_n == DRIVE && cnt_n == '0) ? sel_n : '0;
            busy  <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_am29_latch_bus_arb.sv
// Self-checking bench for am29_latch_bus_arb: directed scenarios plus random
// requests against a transfer-schedule model. Define BUS_LOCK_EN for the lock test.
module tb_am29_latch_bus_arb;

    localparam int N    = 4;
    localparam int HOLD = 2;
    localparam int IDW  = $clog2(N);
    localparam int OW   = 4 * N + 1 + IDW;

    logic           clk;
    logic           rst_;
    logic [N-1:0]   req;
    logic           lock_v;
    logic [N-1:0]   g, oe_, grant, done;
    logic           busy;
    logic [IDW-1:0] owner;
    logic [OW-1:0]  dut_out;
    logic [OW-1:0]  exp_out;

    int checks = 0;
    int errors = 0;

    am29_latch_bus_arb #(.N(N), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .req   (req),
`ifdef BUS_LOCK_EN
        .lock  (lock_v),
`endif
        .g     (g),
        .oe_   (oe_),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .owner (owner)
    );

    assign dut_out = {g, oe_, grant, done, busy, owner};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a transfer is a fixed schedule of frames (1 LATCH, HOLD DRIVEs,
    // the last one carrying done); the arbiter only decides between schedules.
    // Frame kinds: 0 idle, 1 latch, 2 drive, 3 turn, 4 final drive.
    int q_kind[$];
    int cur_kind, cur_owner, m_last;

    function automatic logic [OW-1:0] frame(input int kind, input int own);
        logic [N-1:0] sel;
        logic [N-1:0] fg, foe, fgr, fdn;
        sel = N'(1) << own;
        fg  = (kind == 1) ? sel : '0;
        foe = (kind == 2 || kind == 4) ? ~sel : '1;
        fgr = (kind == 1 || kind == 2 || kind == 4) ? sel : '0;
        fdn = (kind == 4) ? sel : '0;
        return {fg, foe, fgr, fdn, (kind != 0), IDW'(own)};
    endfunction

    function automatic int rr(input logic [N-1:0] rq, input int lst);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (lst + k) % N;
            if (rq[c[IDW-1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic push_transfer();
        q_kind.push_back(1);
        for (int h = 1; h <= HOLD; h++) q_kind.push_back((h == HOLD) ? 4 : 2);
    endtask

    task automatic model_reset();
        q_kind.delete();
        cur_kind  = 0;
        cur_owner = 0;
        m_last    = N - 1;
        exp_out   = frame(0, 0);
    endtask

    task automatic model_step(input logic [N-1:0] rq, input logic lk);
        if (q_kind.size() > 0) begin
            cur_kind = q_kind.pop_front();
        end else if (cur_kind == 4) begin
            if (lk) begin
                push_transfer();
                cur_kind = q_kind.pop_front();
            end else begin
                cur_kind = 3;
                m_last   = cur_owner;
            end
        end else if (cur_kind == 3) begin
            cur_kind = 0;
        end else if (rq != '0) begin
            cur_owner = rr(rq, m_last);
            push_transfer();
            cur_kind = q_kind.pop_front();
        end
        exp_out = frame(cur_kind, cur_owner);
    endtask

    task automatic tick(input logic [N-1:0] rq, input logic lk);
        req    = rq;
        lock_v = lk;
        @(posedge clk);
        model_step(rq, lk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_   = 1'b0;
        req    = '0;
        lock_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_ = 1'b1;
    endtask

    // Bus-safety monitor: never two drivers, never a driver while a latch is open.
    always @(negedge clk) begin
        if (rst_ === 1'b1) begin
            checks++;
            if ($countones(~oe_) > 1 || (oe_ != '1 && g != '0)) begin
                errors++;
                $display("FAIL bus_safety t=%0t oe_=%b g=%b", $time, oe_, g);
            end
        end
    end

    task automatic test_reset();
        do_reset();
        checks++;
        if ({oe_, g, grant, done, busy, owner} !== {4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_values got oe_=%b g=%b grant=%b done=%b busy=%b owner=%0d want 1111/0/0/0/0/0",
                     oe_, g, grant, done, busy, owner);
        end
        for (int i = 0; i < 3; i++) begin
            tick('0, 1'b0);
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, dut_out, exp_out);
            end
        end
    endtask

    task automatic test_single();
        logic [N-1:0] want_oe[5] = '{4'b1111, 4'b1110, 4'b1110, 4'b1111, 4'b1111};
        logic [N-1:0] want_g[5]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [N-1:0] want_dn[5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic         want_bz[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick((i == 0) ? 4'b0001 : 4'b0000, 1'b0);
            checks++;
            if ({g, oe_, done, busy} !== {want_g[i], want_oe[i], want_dn[i], want_bz[i]}) begin
                errors++;
                $display("FAIL single cyc=%0d got g=%b oe_=%b done=%b busy=%b want g=%b oe_=%b done=%b busy=%b",
                         i, g, oe_, done, busy, want_g[i], want_oe[i], want_dn[i], want_bz[i]);
            end
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%h want=%h", i, dut_out, exp_out);
            end
        end
    endtask

    task automatic test_all_req();
        int owners[$];
        int cycles[$];
        do_reset();
        for (int i = 0; i < 25; i++) begin
            tick(4'b1111, 1'b0);
            if (g != '0) begin
                owners.push_back(int'(owner));
                cycles.push_back(i);
            end
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL all_req_model cyc=%0d got=%h want=%h", i, dut_out, exp_out);
            end
        end
        checks++;
        if (owners.size() != 5) begin
            errors++;
            $display("FAIL all_req_count got=%0d want=5", owners.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (owners[k] != (k % N) || (k > 0 && cycles[k] - cycles[k-1] != HOLD + 3)) begin
                    errors++;
                    $display("FAIL all_req_order k=%0d got owner=%0d at cyc %0d want owner=%0d spaced %0d",
                             k, owners[k], cycles[k], k % N, HOLD + 3);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) tick('0, 1'b0);
        tick(4'b0011, 1'b0);
        checks++;
        if (owner !== 2'd0 || g !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_0 got owner=%0d g=%b want owner=0 g=0001", owner, g);
        end
        for (int i = 0; i < 4; i++) tick('0, 1'b0);
        tick(4'b1010, 1'b0);
        checks++;
        if (owner !== 2'd1 || g !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_1 got owner=%0d g=%b want owner=1 g=0010", owner, g);
        end
        checks++;
        if (dut_out !== exp_out) begin
            errors++;
            $display("FAIL wrap_model got=%h want=%h", dut_out, exp_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b0);
        checks++;
        if (oe_ !== 4'b1101) begin
            errors++;
            $display("FAIL areset_pre got oe_=%b want 1101", oe_);
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if ({oe_, g, done, busy} !== {4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL areset_now got oe_=%b g=%b done=%b busy=%b want 1111/0000/0000/0",
                     oe_, g, done, busy);
        end
        @(negedge clk);
        model_reset();
        rst_ = 1'b1;
        tick(4'b0010, 1'b0);
        checks++;
        if (owner !== 2'd1 || g !== 4'b0010 || dut_out !== exp_out) begin
            errors++;
            $display("FAIL areset_after got owner=%0d g=%b out=%h want owner=1 g=0010 out=%h",
                     owner, g, dut_out, exp_out);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        logic         lk;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rq = N'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
`ifdef BUS_LOCK_EN
            lk = ($urandom_range(0, 3) == 0);
`else
            lk = 1'b0;
`endif
            tick(rq, lk);
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL random cyc=%0d req=%b got=%h want=%h", i, rq, dut_out, exp_out);
            end
        end
    endtask

`ifdef BUS_LOCK_EN
    task automatic test_lock();
        int next_owner;
        bit seen_turn;
        do_reset();
        tick(4'b1000, 1'b1);
        for (int i = 0; i < 3 * (HOLD + 1); i++) begin
            tick(4'b1111, 1'b1);
            checks++;
            if (busy !== 1'b1 || owner !== 2'd3 || dut_out !== exp_out) begin
                errors++;
                $display("FAIL lock_hold cyc=%0d got busy=%b owner=%0d out=%h want busy=1 owner=3 out=%h",
                         i, busy, owner, dut_out, exp_out);
            end
        end
        next_owner = -1;
        seen_turn  = 1'b0;
        for (int i = 0; i < 3 * (HOLD + 3); i++) begin
            tick(4'b1111, 1'b0);
            if (busy && grant == '0) seen_turn = 1'b1;
            if (seen_turn && next_owner < 0 && g != '0) next_owner = int'(owner);
            checks++;
            if (dut_out !== exp_out) begin
                errors++;
                $display("FAIL lock_release_model cyc=%0d got=%h want=%h", i, dut_out, exp_out);
            end
        end
        checks++;
        if (!seen_turn || next_owner != 0) begin
            errors++;
            $display("FAIL lock_release got turn=%0d next_owner=%0d want turn=1 next_owner=0",
                     seen_turn, next_owner);
        end
    endtask
`endif

    initial begin
        rst_   = 1'b0;
        req    = '0;
        lock_v = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_all_req();
        test_wrap();
        test_async_reset();
`ifdef BUS_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
